// File: rtl/nfc_pkg.sv
// nfc_pkg -- shared definitions for the NAND flash controller Wishbone slave.
// Holds bus/buffer/row widths, the register address map, the flash command
// codes, the control FSM state type and the error bit positions reported by
// the flash engine.
package nfc_pkg;

    localparam int WB_ADDR_WIDTH  = 16;
    localparam int WB_DATA_WIDTH  = 32;
    localparam int BUF_ADDR_WIDTH = 12;
    localparam int BUF_DATA_WIDTH = 8;
    localparam int ROW_ADDR_WIDTH = 17;
    localparam int BUF_DEPTH      = 2112;   // 2048 data bytes + 64 spare bytes

    // Everything below this address belongs to the page-buffer window.
    localparam logic [WB_ADDR_WIDTH-1:0] BUF_REGION_END = 16'h1000;

    localparam logic [WB_ADDR_WIDTH-1:0] ADDR_ROW   = 16'h1000;
    localparam logic [WB_ADDR_WIDTH-1:0] ADDR_CMD   = 16'h1001;
    localparam logic [WB_ADDR_WIDTH-1:0] ADDR_READY = 16'h1002;
    localparam logic [WB_ADDR_WIDTH-1:0] ADDR_ERROR = 16'h1003;

    typedef enum logic [7:0] {
        CMD_READ_PAGE    = 8'h01,
        CMD_PROGRAM_PAGE = 8'h02,
        CMD_BLOCK_ERASE  = 8'h03,
        CMD_RESET        = 8'h04,
        CMD_READ_ID      = 8'h05
    } nfc_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY
    } nfc_state_e;

    // Bit positions inside eng_err / NFC_ERROR.
    localparam int ERR_ECC_BIT     = 0;
    localparam int ERR_ERASE_BIT   = 1;
    localparam int ERR_PROGRAM_BIT = 2;

    // A command word is valid only when the whole bus word equals one of the
    // codes; the codes are contiguous, so a range check covers them all.
    function automatic logic is_valid_cmd(input logic [WB_DATA_WIDTH-1:0] word);
        return (word[WB_DATA_WIDTH-1:8] == '0) &&
               (word[7:0] >= CMD_READ_PAGE) &&
               (word[7:0] <= CMD_READ_ID);
    endfunction

endpackage

// File: rtl/nfc_wb_slave_if.sv
// nfc_wb_slave_if -- Wishbone classic single-beat bus bundle.
// Signals: wb_addr, wb_data_i_s, wb_we, wb_stb, wb_cyc (master -> slave),
//          wb_ack, wb_data_o_s (slave -> master).
// Modports: master (bus initiator), slave (register/buffer target).
interface nfc_wb_slave_if;
    import nfc_pkg::*;

    logic [WB_ADDR_WIDTH-1:0] wb_addr;
    logic [WB_DATA_WIDTH-1:0] wb_data_i_s;
    logic                     wb_we;
    logic                     wb_stb;
    logic                     wb_cyc;
    logic                     wb_ack;
    logic [WB_DATA_WIDTH-1:0] wb_data_o_s;

    modport master (
        output wb_addr, wb_data_i_s, wb_we, wb_stb, wb_cyc,
        input  wb_ack, wb_data_o_s
    );

    modport slave (
        input  wb_addr, wb_data_i_s, wb_we, wb_stb, wb_cyc,
        output wb_ack, wb_data_o_s
    );

endinterface

// File: rtl/nfc_page_buffer.sv
// nfc_page_buffer -- dual-port page buffer (2048 data + 64 spare bytes).
// Ports:
//   clk_i                                   clock
//   bus_addr/bus_we/bus_wdata -> bus_rdata  Wishbone-side port
//   eng_addr/eng_we/eng_wdata -> eng_rdata  flash-engine-side port
// Both ports read with one cycle of latency. Addresses at or beyond the
// buffer depth drop writes and read back zero. The contents have no reset.
module nfc_page_buffer
    import nfc_pkg::*;
(
    input  logic                      clk_i,
    input  logic [BUF_ADDR_WIDTH-1:0] bus_addr,
    input  logic                      bus_we,
    input  logic [BUF_DATA_WIDTH-1:0] bus_wdata,
    output logic [BUF_DATA_WIDTH-1:0] bus_rdata,
    input  logic [BUF_ADDR_WIDTH-1:0] eng_addr,
    input  logic                      eng_we,
    input  logic [BUF_DATA_WIDTH-1:0] eng_wdata,
    output logic [BUF_DATA_WIDTH-1:0] eng_rdata
);

    logic [BUF_DATA_WIDTH-1:0] mem [0:BUF_DEPTH-1];

    logic bus_in_range;
    logic eng_in_range;

    assign bus_in_range = (bus_addr < BUF_ADDR_WIDTH'(BUF_DEPTH));
    assign eng_in_range = (eng_addr < BUF_ADDR_WIDTH'(BUF_DEPTH));

    // Both ports share the array; the controller never lets the bus write
    // while the engine owns the buffer, so same-address collisions cannot occur.
    always_ff @(posedge clk_i) begin
        if (bus_we && bus_in_range) begin
            mem[bus_addr] <= bus_wdata;
        end
        if (eng_we && eng_in_range) begin
            mem[eng_addr] <= eng_wdata;
        end
        bus_rdata <= bus_in_range ? mem[bus_addr] : '0;
        eng_rdata <= eng_in_range ? mem[eng_addr] : '0;
    end

endmodule

// File: rtl/nfc_wb_slave.sv
// nfc_wb_slave -- Wishbone slave front end of a NAND flash controller.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   wb                        Wishbone slave bundle (nfc_wb_slave_if.slave)
//   eng_cmd_valid/eng_cmd/eng_row, eng_cmd_ready   command handshake to engine
//   eng_done, eng_err         engine completion pulse and {program,erase,ecc} errors
//   eng_buf_addr/eng_buf_we/eng_buf_wdata/eng_buf_rdata   engine buffer port
// Address map: 0x0000-0x083F page buffer, 0x1000 ROW_ADDR, 0x1001 NFC_CMD,
// 0x1002 NFC_READY, 0x1003 NFC_ERROR; everything else reads 0.
module nfc_wb_slave
    import nfc_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    nfc_wb_slave_if.slave             wb,
    output logic                      eng_cmd_valid,
    output logic [7:0]                eng_cmd,
    output logic [ROW_ADDR_WIDTH-1:0] eng_row,
    input  logic                      eng_cmd_ready,
    input  logic                      eng_done,
    input  logic [2:0]                eng_err,
    input  logic [BUF_ADDR_WIDTH-1:0] eng_buf_addr,
    input  logic                      eng_buf_we,
    input  logic [BUF_DATA_WIDTH-1:0] eng_buf_wdata,
    output logic [BUF_DATA_WIDTH-1:0] eng_buf_rdata
);

    nfc_state_e state;
    nfc_state_e state_next;

    logic                      ack_q;
    logic                      rd_from_buf_q;
    logic [WB_DATA_WIDTH-1:0]  reg_rdata_q;
    logic [WB_DATA_WIDTH-1:0]  reg_rdata_next;
    logic [BUF_DATA_WIDTH-1:0] buf_bus_rdata;

    logic [ROW_ADDR_WIDTH-1:0] row_addr;
    logic                      nfc_ready;
    logic [2:0]                nfc_error;

    logic bus_req;
    logic wr_req;
    logic idle;
    logic addr_is_buf;
    logic buf_we;
    logic row_we;
    logic cmd_start;

    // A request is taken only when no ack is pending, which also guarantees
    // that ack can never be high on two consecutive cycles.
    assign bus_req     = wb.wb_stb & wb.wb_cyc & ~ack_q;
    assign wr_req      = bus_req & wb.wb_we;
    assign idle        = (state == ST_IDLE);
    assign addr_is_buf = (wb.wb_addr < BUF_REGION_END);

    // While a flash operation is in flight all writes are acked but dropped,
    // so the engine owns the buffer and the command registers stay frozen.
    assign buf_we    = wr_req & addr_is_buf & idle;
    assign row_we    = wr_req & (wb.wb_addr == ADDR_ROW) & idle;
    assign cmd_start = wr_req & (wb.wb_addr == ADDR_CMD) & idle & is_valid_cmd(wb.wb_data_i_s);

    nfc_page_buffer u_page_buffer (
        .clk_i     (clk_i),
        .bus_addr  (wb.wb_addr[BUF_ADDR_WIDTH-1:0]),
        .bus_we    (buf_we),
        .bus_wdata (wb.wb_data_i_s[BUF_DATA_WIDTH-1:0]),
        .bus_rdata (buf_bus_rdata),
        .eng_addr  (eng_buf_addr),
        .eng_we    (eng_buf_we),
        .eng_wdata (eng_buf_wdata),
        .eng_rdata (eng_buf_rdata)
    );

    // Control FSM: state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control FSM: next state. In ISSUE a simultaneous eng_done is ignored
    // because only the ready handshake is looked at there.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (cmd_start)     state_next = ST_ISSUE;
            ST_ISSUE: if (eng_cmd_ready) state_next = ST_BUSY;
            ST_BUSY:  if (eng_done)      state_next = ST_IDLE;
            default:                     state_next = ST_IDLE;
        endcase
    end

    // Control FSM: outputs.
    always_comb begin
        eng_cmd_valid = (state == ST_ISSUE);
    end

    // Command/status registers. eng_cmd and eng_row are latched when the
    // command is accepted so they stay stable for the whole ISSUE phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_addr  <= '0;
            eng_cmd   <= '0;
            eng_row   <= '0;
            nfc_ready <= 1'b1;
            nfc_error <= '0;
        end else begin
            if (row_we) begin
                row_addr <= wb.wb_data_i_s[ROW_ADDR_WIDTH-1:0];
            end
            if (cmd_start) begin
                eng_cmd   <= wb.wb_data_i_s[7:0];
                eng_row   <= row_addr;
                nfc_ready <= 1'b0;
                nfc_error <= '0;
            end else if ((state == ST_BUSY) && eng_done) begin
                nfc_ready <= 1'b1;
                nfc_error <= eng_err;
            end
        end
    end

    // Register read mux, sampled on the edge that accepts the request.
    always_comb begin
        reg_rdata_next = '0;
        case (wb.wb_addr)
            ADDR_ROW:   reg_rdata_next[ROW_ADDR_WIDTH-1:0] = row_addr;
            ADDR_READY: reg_rdata_next[0]                  = nfc_ready;
            ADDR_ERROR: reg_rdata_next[2:0]                = nfc_error;
            default:    reg_rdata_next                     = '0;
        endcase
    end

    // Bus response: ack one cycle after acceptance. Buffer reads take their
    // data straight from the RAM output, which lands in the ack cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q         <= 1'b0;
            rd_from_buf_q <= 1'b0;
            reg_rdata_q   <= '0;
        end else begin
            ack_q         <= bus_req;
            rd_from_buf_q <= addr_is_buf;
            reg_rdata_q   <= reg_rdata_next;
        end
    end

    assign wb.wb_ack = ack_q;

    always_comb begin
        wb.wb_data_o_s = '0;
        if (ack_q) begin
            if (rd_from_buf_q) begin
                wb.wb_data_o_s = {{(WB_DATA_WIDTH-BUF_DATA_WIDTH){1'b0}}, buf_bus_rdata};
            end else begin
                wb.wb_data_o_s = reg_rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_nfc_wb_slave.sv
// tb_nfc_wb_slave -- self-checking bench for nfc_wb_slave.
// Drives the Wishbone bundle and a scripted flash engine, and compares bus
// reads and engine-side outputs against values derived from the register map.
module tb_nfc_wb_slave;
    import nfc_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        eng_cmd_valid;
    logic [7:0]  eng_cmd;
    logic [16:0] eng_row;
    logic        eng_cmd_ready;
    logic        eng_done;
    logic [2:0]  eng_err;
    logic [11:0] eng_buf_addr;
    logic        eng_buf_we;
    logic [7:0]  eng_buf_wdata;
    logic [7:0]  eng_buf_rdata;

    int total = 0;
    int bad   = 0;

    // Reference model state for the randomized test.
    logic [7:0]  mem_model [0:BUF_DEPTH-1];
    bit          mem_known [0:BUF_DEPTH-1];
    logic [16:0] row_model;
    logic        ready_model;
    logic [2:0]  err_model;

    always #5 clk_i = ~clk_i;

    nfc_wb_slave_if bus ();

    nfc_wb_slave dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .wb            (bus),
        .eng_cmd_valid (eng_cmd_valid),
        .eng_cmd       (eng_cmd),
        .eng_row       (eng_row),
        .eng_cmd_ready (eng_cmd_ready),
        .eng_done      (eng_done),
        .eng_err       (eng_err),
        .eng_buf_addr  (eng_buf_addr),
        .eng_buf_we    (eng_buf_we),
        .eng_buf_wdata (eng_buf_wdata),
        .eng_buf_rdata (eng_buf_rdata)
    );

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // One Wishbone transfer. ack_ok is set only when ack arrives on the first
    // edge after the request and is gone on the following edge.
    task automatic bus_xfer(input logic [15:0] addr, input logic we, input logic [31:0] wdata,
                            output logic [31:0] rdata, output bit ack_ok, output logic valid_at_ack);
        bit acked;
        int lat;
        acked = 0;
        lat = 0;
        rdata = '0;
        valid_at_ack = 1'b0;
        @(negedge clk_i);
        bus.wb_addr     = addr;
        bus.wb_we       = we;
        bus.wb_data_i_s = wdata;
        bus.wb_stb      = 1'b1;
        bus.wb_cyc      = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i);
            #1;
            lat++;
            if (bus.wb_ack) begin
                acked = 1;
                break;
            end
        end
        rdata        = bus.wb_data_o_s;
        valid_at_ack = eng_cmd_valid;
        bus.wb_stb   = 1'b0;
        bus.wb_cyc   = 1'b0;
        bus.wb_we    = 1'b0;
        @(posedge clk_i);
        #1;
        ack_ok = acked && (lat == 1) && !bus.wb_ack;
    endtask

    task automatic wb_write(input logic [15:0] addr, input logic [31:0] data, output bit ack_ok);
        logic [31:0] dummy;
        logic        v;
        bus_xfer(addr, 1'b1, data, dummy, ack_ok, v);
    endtask

    task automatic wb_read(input logic [15:0] addr, output logic [31:0] data, output bit ack_ok);
        logic v;
        bus_xfer(addr, 1'b0, 32'h0, data, ack_ok, v);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic engine_accept(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (eng_cmd_valid) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            eng_cmd_ready = 1'b1;
            @(negedge clk_i);
            eng_cmd_ready = 1'b0;
        end
    endtask

    task automatic engine_finish(input logic [2:0] err);
        @(negedge clk_i);
        eng_done = 1'b1;
        eng_err  = err;
        @(negedge clk_i);
        eng_done = 1'b0;
        eng_err  = '0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        bit ok;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        total++; if (bus.wb_ack !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b want 0", bus.wb_ack); end
        total++; if (bus.wb_data_o_s !== 32'h0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", bus.wb_data_o_s); end
        total++; if (eng_cmd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", eng_cmd_valid); end
        total++; if (eng_cmd !== 8'h0 || eng_row !== 17'h0) begin bad++; $display("[TB] FAIL reset_cmd_row: got %h/%h want 0/0", eng_cmd, eng_row); end
        wb_read(ADDR_ROW, rd, ok);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_row_addr: got %h want 0", rd); end
        wb_read(ADDR_READY, rd, ok);
        total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL reset_ready: got %h want 1", rd); end
        wb_read(ADDR_ERROR, rd, ok);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_error: got %h want 0", rd); end
    endtask

    task automatic test_row_addr();
        logic [31:0] rd;
        bit ok;
        wb_write(ADDR_ROW, 32'h0000_0123, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL row_write_ack: got %b want 1", ok); end
        wb_read(ADDR_ROW, rd, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL row_read_ack: got %b want 1", ok); end
        total++; if (rd !== 32'h0000_0123) begin bad++; $display("[TB] FAIL row_readback: got %h want 00000123", rd); end
        wb_write(ADDR_ROW, 32'hFFFF_FFFF, ok);
        wb_read(ADDR_ROW, rd, ok);
        total++; if (rd !== 32'h0001_FFFF) begin bad++; $display("[TB] FAIL row_width: got %h want 0001ffff", rd); end
        wb_read(ADDR_CMD, rd, ok);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL cmd_reads_zero: got %h want 0", rd); end
    endtask

    task automatic test_buffer();
        logic [31:0] rd;
        bit ok;
        wb_write(16'h0005, 32'h1234_56A5, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL buf_write_ack: got %b want 1", ok); end
        wb_read(16'h0005, rd, ok);
        total++; if (rd !== 32'h0000_00A5) begin bad++; $display("[TB] FAIL buf_readback: got %h want 000000a5", rd); end
        wb_write(16'h083F, 32'h0000_005A, ok);
        wb_read(16'h083F, rd, ok);
        total++; if (rd !== 32'h0000_005A) begin bad++; $display("[TB] FAIL buf_last_byte: got %h want 0000005a", rd); end
        wb_write(16'h0900, 32'h0000_00FF, ok);
        wb_read(16'h0900, rd, ok);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL buf_out_of_range: got %h want 0", rd); end
        wb_read(16'h2000, rd, ok);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL unmapped_read: got %h want 0", rd); end
    endtask

    task automatic test_engine_port();
        logic [31:0] rd;
        bit ok;
        @(negedge clk_i);
        eng_buf_addr = 12'h010; eng_buf_wdata = 8'h3C; eng_buf_we = 1'b1;
        @(negedge clk_i);
        eng_buf_we = 1'b0;
        wb_read(16'h0010, rd, ok);
        total++; if (rd !== 32'h0000_003C) begin bad++; $display("[TB] FAIL eng_write_bus_read: got %h want 0000003c", rd); end
        wb_write(16'h0020, 32'h0000_0077, ok);
        @(negedge clk_i);
        eng_buf_addr = 12'h020;
        @(negedge clk_i);
        total++; if (eng_buf_rdata !== 8'h77) begin bad++; $display("[TB] FAIL bus_write_eng_read: got %h want 77", eng_buf_rdata); end
        eng_buf_addr = 12'h900; eng_buf_wdata = 8'h55; eng_buf_we = 1'b1;
        @(negedge clk_i);
        eng_buf_we = 1'b0;
        @(negedge clk_i);
        total++; if (eng_buf_rdata !== 8'h00) begin bad++; $display("[TB] FAIL eng_out_of_range: got %h want 00", eng_buf_rdata); end
        eng_buf_addr = 12'h000;
    endtask

    task automatic test_command();
        logic [31:0] rd;
        logic [31:0] dummy;
        logic        v;
        bit ok;
        int cnt;
        bit stable_ok;
        bit saw_valid;
        wb_write(ADDR_ROW, 32'h0000_ABCD, ok);
        bus_xfer(ADDR_CMD, 1'b1, 32'h0000_0002, dummy, ok, v);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL cmd_write_ack: got %b want 1", ok); end
        cnt = v ? 1 : 0;
        stable_ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (eng_cmd_valid) begin
                cnt++;
                if (eng_cmd !== 8'h02 || eng_row !== 17'h0ABCD) stable_ok = 0;
                if (cnt == 3) eng_cmd_ready = 1'b1;
            end else if (cnt > 0) begin
                break;
            end
        end
        eng_cmd_ready = 1'b0;
        total++; if (cnt !== 3) begin bad++; $display("[TB] FAIL cmd_valid_cycles: got %0d want 3", cnt); end
        total++; if (stable_ok !== 1'b1) begin bad++; $display("[TB] FAIL cmd_stable: got cmd=%h row=%h want 02/0abcd", eng_cmd, eng_row); end
        wb_read(ADDR_READY, rd, ok);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL busy_ready: got %h want 0", rd); end

        // Writes while busy are acked but have no effect.
        wb_write(ADDR_CMD, 32'h0000_0003, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL busy_cmd_ack: got %b want 1", ok); end
        wb_write(16'h0005, 32'h0000_0011, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL busy_buf_ack: got %b want 1", ok); end
        wb_write(ADDR_ROW, 32'h0000_0001, ok);
        saw_valid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (eng_cmd_valid) saw_valid = 1;
        end
        total++; if (saw_valid !== 1'b0) begin bad++; $display("[TB] FAIL busy_no_reissue: got %b want 0", saw_valid); end
        wb_read(16'h0005, rd, ok);
        total++; if (rd !== 32'h0000_00A5) begin bad++; $display("[TB] FAIL busy_buf_kept: got %h want 000000a5", rd); end
        wb_read(ADDR_ROW, rd, ok);
        total++; if (rd !== 32'h0000_ABCD) begin bad++; $display("[TB] FAIL busy_row_kept: got %h want 0000abcd", rd); end

        engine_finish(3'b100);
        wb_read(ADDR_READY, rd, ok);
        total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL done_ready: got %h want 1", rd); end
        wb_read(ADDR_ERROR, rd, ok);
        total++; if (rd !== 32'h4) begin bad++; $display("[TB] FAIL done_error: got %h want 4", rd); end

        // A new command clears the error immediately.
        wb_write(ADDR_CMD, 32'h0000_0004, ok);
        wb_read(ADDR_ERROR, rd, ok);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL error_cleared: got %h want 0", rd); end
        total++; if (eng_cmd !== 8'h04) begin bad++; $display("[TB] FAIL second_cmd_code: got %h want 04", eng_cmd); end
        engine_accept(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL second_cmd_issue: got %b want 1", ok); end
        engine_finish(3'b000);
    endtask

    task automatic test_invalid_and_stray();
        logic [31:0] rd;
        bit ok;
        bit saw_valid;
        wb_write(ADDR_CMD, 32'h0000_0000, ok);
        wb_write(ADDR_CMD, 32'h0000_0006, ok);
        wb_write(ADDR_CMD, 32'h0000_0101, ok);
        saw_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (eng_cmd_valid) saw_valid = 1;
        end
        total++; if (saw_valid !== 1'b0) begin bad++; $display("[TB] FAIL invalid_cmd_issued: got %b want 0", saw_valid); end
        engine_finish(3'b111);
        wb_read(ADDR_ERROR, rd, ok);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL stray_done_idle: got %h want 0", rd); end

        // Ready and done together in ISSUE: handshake taken, done ignored.
        wb_write(ADDR_CMD, 32'h0000_0001, ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (eng_cmd_valid) begin ok = 1; break; end
        end
        eng_cmd_ready = 1'b1; eng_done = 1'b1; eng_err = 3'b111;
        @(negedge clk_i);
        eng_cmd_ready = 1'b0; eng_done = 1'b0; eng_err = 3'b000;
        total++; if (eng_cmd_valid !== 1'b0) begin bad++; $display("[TB] FAIL issue_handshake: got %b want 0", eng_cmd_valid); end
        wb_read(ADDR_READY, rd, ok);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL issue_done_ignored: got %h want 0", rd); end
        engine_finish(3'b001);
        wb_read(ADDR_ERROR, rd, ok);
        total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL ecc_error: got %h want 1", rd); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd;
        bit ok;
        bit saw_valid;
        wb_write(ADDR_ROW, 32'h0000_0777, ok);
        wb_write(ADDR_CMD, 32'h0000_0005, ok);
        engine_accept(ok);
        do_reset();
        total++; if (eng_cmd_valid !== 1'b0) begin bad++; $display("[TB] FAIL busy_reset_valid: got %b want 0", eng_cmd_valid); end
        wb_read(ADDR_READY, rd, ok);
        total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL busy_reset_ready: got %h want 1", rd); end
        engine_finish(3'b111);
        wb_read(ADDR_ERROR, rd, ok);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL post_reset_done: got %h want 0", rd); end
        wb_read(ADDR_ROW, rd, ok);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL reset_row_cleared: got %h want 0", rd); end

        // Reset while still waiting for the engine to take the command.
        wb_write(ADDR_ROW, 32'h0000_0042, ok);
        wb_write(ADDR_CMD, 32'h0000_0003, ok);
        @(negedge clk_i);
        total++; if (eng_cmd_valid !== 1'b1) begin bad++; $display("[TB] FAIL issue_before_reset: got %b want 1", eng_cmd_valid); end
        do_reset();
        total++; if (eng_cmd_valid !== 1'b0 || eng_cmd !== 8'h0 || eng_row !== 17'h0) begin
            bad++; $display("[TB] FAIL issue_reset: got valid=%b cmd=%h row=%h want 0/00/00000", eng_cmd_valid, eng_cmd, eng_row);
        end
        eng_cmd_ready = 1'b1;
        saw_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (eng_cmd_valid) saw_valid = 1;
        end
        eng_cmd_ready = 1'b0;
        total++; if (saw_valid !== 1'b0) begin bad++; $display("[TB] FAIL issue_abandoned: got %b want 0", saw_valid); end
    endtask

    // Expected value of a bus read under the register map; returns 0 when
    // the buffer byte has never been written in this test.
    function automatic bit model_read(input logic [15:0] a, output logic [31:0] exp);
        exp = '0;
        if (a < 16'h1000) begin
            if (int'(a) < BUF_DEPTH) begin
                if (!mem_known[a]) return 0;
                exp = {24'h0, mem_model[a]};
            end
            return 1;
        end
        case (a)
            16'h1000: exp = {15'h0, row_model};
            16'h1002: exp = {31'h0, ready_model};
            16'h1003: exp = {29'h0, err_model};
            default:  exp = '0;
        endcase
        return 1;
    endfunction

    function automatic logic [15:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r < 8) return 16'($urandom_range(0, 63));
        if (r == 8) return 16'(16'h083F - $urandom_range(0, 3));
        if (r == 9) return 16'($urandom_range(16'h0840, 16'h0FFF));
        if (r < 14) return 16'($urandom_range(16'h1000, 16'h1003));
        return 16'($urandom_range(16'h1004, 16'hFFFF));
    endfunction

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] exp;
        logic [31:0] wd;
        logic [15:0] a;
        bit ok;
        do_reset();
        row_model = '0; ready_model = 1'b1; err_model = '0;
        for (int i = 0; i < BUF_DEPTH; i++) mem_known[i] = 0;
        for (int n = 0; n < 150; n++) begin
            a  = rand_addr();
            wd = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                if (a == ADDR_CMD) begin
                    do wd = $urandom_range(0, 255); while (wd >= 1 && wd <= 5);
                end
                wb_write(a, wd, ok);
                if (int'(a) < BUF_DEPTH) begin
                    mem_model[a] = wd[7:0];
                    mem_known[a] = 1;
                end else if (a == ADDR_ROW) begin
                    row_model = wd[16:0];
                end
                total++; if (ok !== 1'b1 || eng_cmd_valid !== 1'b0) begin
                    bad++; $display("[TB] FAIL rand_write %h: got ack_ok=%b valid=%b want 1/0", a, ok, eng_cmd_valid);
                end
            end else begin
                wb_read(a, rd, ok);
                if (model_read(a, exp)) begin
                    total++; if (rd !== exp || ok !== 1'b1) begin
                        bad++; $display("[TB] FAIL rand_read %h: got %h ack_ok=%b want %h", a, rd, ok, exp);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        bus.wb_addr = '0; bus.wb_data_i_s = '0; bus.wb_we = 1'b0; bus.wb_stb = 1'b0; bus.wb_cyc = 1'b0;
        eng_cmd_ready = 1'b0; eng_done = 1'b0; eng_err = '0;
        eng_buf_addr = '0; eng_buf_we = 1'b0; eng_buf_wdata = '0;
        test_reset();
        test_row_addr();
        test_buffer();
        test_engine_port();
        test_command();
        test_invalid_and_stray();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nfc_wb_slave.md
NFC_WB_SLAVE -- requirements
Module: nfc_wb_slave

Interface
REQ-001 WB_ADDR_WIDTH, 16, Wishbone address width.
REQ-002 WB_DATA_WIDTH, 32, Wishbone data width.
REQ-003 BUF_ADDR_WIDTH, 12, page-buffer address width.
REQ-004 BUF_DATA_WIDTH, 8, page-buffer data width.
REQ-005 ROW_ADDR_WIDTH, 17, flash row address width.
REQ-006 BUF_DEPTH, 2112, page-buffer bytes (2048 data + 64 spare).
REQ-007 clk_i  in  1  system clock. One clock; reset is synchronous and active-high.
REQ-008 rst_i  in  1  reset, synchronous, active-high.
REQ-009 wb_addr in WB_ADDR_WIDTH; wb_data_i_s in WB_DATA_WIDTH; wb_we, wb_stb, wb_cyc in 1: Wishbone slave inputs.
REQ-010 wb_ack out 1; wb_data_o_s out WB_DATA_WIDTH: Wishbone slave outputs.
REQ-011 eng_cmd_valid out 1; eng_cmd out 8; eng_row out ROW_ADDR_WIDTH: command to flash engine.
REQ-012 eng_cmd_ready in 1: engine accepts the command.
REQ-013 eng_done in 1: single-cycle completion pulse. eng_err in 3: {program, erase, ecc} errors, valid with eng_done.
REQ-014 eng_buf_addr in BUF_ADDR_WIDTH; eng_buf_we in 1; eng_buf_wdata in 8; eng_buf_rdata out 8: engine buffer port.

Function
REQ-015 Address map SHALL be: 0x0000-0x083F buffer; 0x1000 ROW_ADDR (RW); 0x1001 NFC_CMD (W; reads 0); 0x1002 NFC_READY (R, bit0); 0x1003 NFC_ERROR (R, bits2:0); all other addresses read 0, ignore writes.
REQ-016 wb_ack SHALL assert exactly one cycle after a clock edge sampling wb_stb&wb_cyc&!wb_ack, for one cycle only; it SHALL never be asserted on consecutive cycles.
REQ-017 wb_data_o_s SHALL be valid while wb_ack=1, zero-extended; buffer reads use 1-cycle synchronous RAM read.
REQ-018 Buffer writes SHALL store wb_data_i_s[7:0]; ROW_ADDR writes store wb_data_i_s[ROW_ADDR_WIDTH-1:0].
REQ-019 Control FSM SHALL have states IDLE, ISSUE, BUSY.
REQ-020 IDLE: NFC_CMD write of a valid code (READ_PAGE 0x01, PROGRAM_PAGE 0x02, BLOCK_ERASE 0x03, RESET 0x04, READ_ID 0x05) -> ISSUE; NFC_READY and NFC_ERROR cleared in the same edge; invalid codes ignored, state stays IDLE.
REQ-021 ISSUE: eng_cmd_valid=1 with eng_cmd/eng_row stable until the cycle eng_cmd_ready=1, then -> BUSY.
REQ-022 BUSY: on eng_done -> IDLE, NFC_READY=1, NFC_ERROR=eng_err.
REQ-023 In ISSUE/BUSY, NFC_CMD, ROW_ADDR and buffer writes SHALL be acknowledged but dropped; reads remain served.
REQ-024 eng_done outside BUSY SHALL be ignored.
REQ-025 eng_done and eng_cmd_ready in the same cycle in ISSUE: ready handshake taken, done ignored.
REQ-026 Buffer addresses 0x0840-0x0FFF: reads return 0; writes dropped; engine port addresses >= BUF_DEPTH likewise.

Reset
REQ-027 On rst_i, next edge SHALL set: state IDLE, wb_ack=0, wb_data_o_s=0, eng_cmd_valid=0, eng_cmd=0, eng_row=0, ROW_ADDR=0, NFC_READY=1, NFC_ERROR=0; buffer contents not cleared.
REQ-028 Reset in ISSUE/BUSY SHALL abandon the operation with no further handshake.

Structure
REQ-029 Shared package nfc_pkg SHALL hold register addresses, command codes, state enum, and error bit indices.
REQ-030 Buffer SHALL be sub-module nfc_page_buffer: dual-port, one port bus-side, one engine-side, 1-cycle read latency; collisions excluded by REQ-023.

Verification
REQ-031 Write 0x1000=0x00123, read back -> wb_data_o_s=0x00000123, each ack one cycle wide.
REQ-032 Write buffer 0x0005=0xA5, read 0x0005 -> 0x000000A5; read 0x0900 -> 0.
REQ-033 Write 0x1001=0x02, eng_cmd_ready after 3 cycles -> eng_cmd_valid high 3 cycles, eng_cmd=0x02, eng_row=ROW_ADDR; NFC_READY reads 0 until done.
REQ-034 eng_done with eng_err=3'b100 -> NFC_READY=1, NFC_ERROR reads 0x4; next command clears it to 0.
REQ-035 In BUSY write 0x1001=0x03 and buffer 0x0005=0x11 -> acked, no new eng_cmd_valid, buffer still 0xA5.
REQ-036 rst_i in BUSY -> next cycle NFC_READY=1, eng_cmd_valid=0; later eng_done ignored.
